// File: rtl/ext_pipe.sv
// Registered immediate extender: decodes the extension mode on the input side and
// queues the extended value with its illegal-mode flag in a small output FIFO.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    imm_in,
    input  logic [2:0]         ext_op,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   imm_out,
    output logic               illegal_out,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_ZERO   = 3'b000;
    localparam logic [2:0] OP_SIGN   = 3'b001;
    localparam logic [2:0] OP_HIGH   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_BYTE_S = 3'b100;
    localparam logic [2:0] OP_BYTE_Z = 3'b101;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic signed [OUT_W-1:0] w_sext;
    logic signed [OUT_W-1:0] w_branch;
    logic        [OUT_W-1:0] w_ext_p0;
    logic                    w_ill_p0;
    logic                    w_push;
    logic                    w_pop;

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic             r_ill [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [ERR_W-1:0] r_err_cnt;

    // Input stage: combinational extension of the offered immediate
    assign w_sext   = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};
    assign w_branch = w_sext <<< 2;

    always_comb begin
        w_ext_p0 = '0;
        w_ill_p0 = 1'b0;
        case (ext_op)
            OP_ZERO:   w_ext_p0 = {{(OUT_W-IN_W){1'b0}}, imm_in};
            OP_SIGN:   w_ext_p0 = w_sext;
            OP_HIGH:   w_ext_p0 = {imm_in, {(OUT_W-IN_W){1'b0}}};
            OP_BRANCH: w_ext_p0 = w_branch;
            OP_BYTE_S: w_ext_p0 = {{(OUT_W-8){imm_in[7]}}, imm_in[7:0]};
            OP_BYTE_Z: w_ext_p0 = {{(OUT_W-8){1'b0}}, imm_in[7:0]};
            default:   w_ill_p0 = 1'b1;
        endcase
    end

    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // Storage stage: entries are cleared on reset so the head is never X
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
                r_ill[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_ext_p0;
            r_ill[r_wr_ptr] <= w_ill_p0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Error counter survives flush; only reset clears it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                  r_err_cnt <= '0;
        else if (w_push && w_ill_p0) r_err_cnt <= sat_inc(r_err_cnt);
    end

    assign imm_out     = r_mem[r_rd_ptr];
    assign illegal_out = r_ill[r_rd_ptr];
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: default-width instance plus a 2-bit error counter instance.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, flush, out_valid, out_ready, illegal_out;
    logic [15:0] imm_in;
    logic [2:0]  ext_op;
    logic [31:0] imm_out;
    logic [7:0]  err_cnt;

    logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready, s_illegal;
    logic [15:0] s_imm_in;
    logic [2:0]  s_ext_op;
    logic [31:0] s_imm_out;
    logic [1:0]  s_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] vec_imm [8];
    logic [2:0]  vec_op  [8];
    logic [31:0] vec_exp [8];
    logic [15:0] v;

    always #5 clk = ~clk;

    ext_pipe u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .imm_in(imm_in), .ext_op(ext_op), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .imm_out(imm_out), .illegal_out(illegal_out),
        .err_cnt(err_cnt)
    );

    ext_pipe #(.ERR_W(2)) u_sat (
        .clk(clk), .rstn(rstn), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .imm_in(s_imm_in), .ext_op(s_ext_op), .flush(s_flush), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .imm_out(s_imm_out), .illegal_out(s_illegal),
        .err_cnt(s_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_imm[0] = 16'h8F01; vec_op[0] = 3'b000; vec_exp[0] = 32'h0000_8F01;
        vec_imm[1] = 16'h8F01; vec_op[1] = 3'b001; vec_exp[1] = 32'hFFFF_8F01;
        vec_imm[2] = 16'h8F01; vec_op[2] = 3'b010; vec_exp[2] = 32'h8F01_0000;
        vec_imm[3] = 16'h8F01; vec_op[3] = 3'b011; vec_exp[3] = 32'hFFFE_3C04;
        vec_imm[4] = 16'h8F01; vec_op[4] = 3'b100; vec_exp[4] = 32'h0000_0001;
        vec_imm[5] = 16'h8F01; vec_op[5] = 3'b101; vec_exp[5] = 32'h0000_0001;
        vec_imm[6] = 16'h00F0; vec_op[6] = 3'b100; vec_exp[6] = 32'hFFFF_FFF0;
        vec_imm[7] = 16'h00F0; vec_op[7] = 3'b101; vec_exp[7] = 32'h0000_00F0;

        rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        imm_in = '0; ext_op = '0;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
        s_imm_in = 16'h1234; s_ext_op = 3'b111;
        repeat (2) step();
        rstn = 1'b1;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_imm_out", imm_out, 0);
        check("rst_illegal", illegal_out, 0);
        check("rst_err_cnt", err_cnt, 0);

        // single entries, one per mode
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; imm_in = vec_imm[i]; ext_op = vec_op[i];
            step();
            in_valid = 1'b0;
            check($sformatf("mode%0d_valid", i), out_valid, 1);
            check($sformatf("mode%0d_value", i), imm_out, vec_exp[i]);
            check($sformatf("mode%0d_illegal", i), illegal_out, 0);
        end
        step();
        check("modes_drained", out_valid, 0);

        // backpressure with a 2-entry FIFO
        out_ready = 1'b0;
        in_valid = 1'b1; ext_op = 3'b000; imm_in = 16'd1;
        step();
        check("bp_ready_after1", in_ready, 1);
        imm_in = 16'd2;
        step();
        check("bp_ready_after2", in_ready, 0);
        imm_in = 16'd3;
        step();
        check("bp_stalled_ready", in_ready, 0);
        check("bp_head_hold", imm_out, 1);
        check("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("bp_out1_popped_head2", imm_out, 2);
        check("bp_ready_reopen", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_head3", imm_out, 3);
        check("bp_head3_valid", out_valid, 1);
        step();
        check("bp_drained", out_valid, 0);

        // streaming SIGN values, one per cycle
        for (int i = 0; i < 100; i++) begin
            v = 16'(i * 613 + 7);
            in_valid = 1'b1; ext_op = 3'b001; imm_in = v;
            step();
            check($sformatf("stream%0d_value", i), imm_out, {{16{v[15]}}, v});
            check($sformatf("stream%0d_valid", i), out_valid, 1);
            check($sformatf("stream%0d_ready", i), in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", out_valid, 0);

        // illegal ops
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; ext_op = 3'b110; imm_in = 16'hBEEF;
            step();
            check($sformatf("ill%0d_value", i), imm_out, 0);
            check($sformatf("ill%0d_flag", i), illegal_out, 1);
        end
        in_valid = 1'b0;
        step();
        check("ill_err_cnt", err_cnt, 3);

        // saturation on the 2-bit counter instance
        s_in_valid = 1'b1;
        repeat (2) step();
        check("sat_after2", s_err, 2);
        repeat (3) step();
        s_in_valid = 1'b0;
        step();
        check("sat_after5", s_err, 3);

        // flush with two queued entries and a same-cycle input
        out_ready = 1'b0;
        in_valid = 1'b1; ext_op = 3'b000; imm_in = 16'h00AA;
        step();
        imm_in = 16'h00BB;
        step();
        check("fl_full_valid", out_valid, 1);
        check("fl_full_ready", in_ready, 0);
        flush = 1'b1; ext_op = 3'b110;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_err_kept", err_cnt, 3);
        step();
        check("fl_stays_empty", out_valid, 0);

        // flush with room available: the offered illegal entry must be dropped
        in_valid = 1'b1; ext_op = 3'b000; imm_in = 16'h0055;
        step();
        flush = 1'b1; out_ready = 1'b1; ext_op = 3'b110;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_valid", out_valid, 0);
        check("fl2_err_no_count", err_cnt, 3);
        step();
        check("fl2_input_dropped", out_valid, 0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; ext_op = 3'b001; imm_in = 16'h1357;
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", out_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_imm_out", imm_out, 0);
        check("ar_err_cnt", err_cnt, 0);
        check("ar_sat_err", s_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar_post_ready", in_ready, 1);
        check("ar_post_valid", out_valid, 0);
        in_valid = 1'b1; ext_op = 3'b001; imm_in = 16'h8F01;
        step();
        in_valid = 1'b0;
        check("ar_first_valid", out_valid, 1);
        check("ar_first_value", imm_out, 32'hFFFF_8F01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
